// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter
//   Round-robin owner of a single downstream port shared by NUM_REQ requesters.
//   Grants are registered and ownership lasts until the owner releases it.
//   Every change of owner passes through exactly one dead (TURN) cycle.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   req         : per-requester request level
//   done        : per-requester release pulse (only the owner's bit counts)
//   req_data    : packed requester data, slot i at [i*DATA_W +: DATA_W]
//   gnt         : registered one-hot grant (zero in IDLE/TURN)
//   gnt_id      : index of the current/last owner (held while idle)
//   bus_valid   : high while an owner holds the bus
//   bus_data    : owner's data slice, zero when bus_valid is low
//   timeout     : one-cycle pulse in the TURN after a forced release
//                 (present only with SHARED_PORT_ARBITER_TIMEOUT_EN)
//
// Build option
//   SHARED_PORT_ARBITER_TIMEOUT_EN : bounds ownership to MAX_HOLD cycles.
module shared_port_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 8,
  parameter  int MAX_HOLD = 15,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        done,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [IDW-1:0]            gnt_id,
  output logic                      bus_valid,
  output logic [DATA_W-1:0]         bus_data
`ifdef SHARED_PORT_ARBITER_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W < 1 || MAX_HOLD < 1) begin : g_cfg_check
    $error("shared_port_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic                 bus_valid_q, bus_valid_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;

  logic                 win_found;
  logic [IDW-1:0]       win_id;
  logic [IDW-1:0]       cand;
  logic                 owner_rel;
  logic                 rel_forced;

`ifdef SHARED_PORT_ARBITER_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                 timeout_q, timeout_d;

  // A done/req-drop in the last allowed cycle wins over the forced release.
  always_comb begin
    rel_forced = (state_q == OWN) && !owner_rel && (hold_cnt_q == HCW'(MAX_HOLD - 1));
    hold_cnt_d = (state_q == OWN) ? hold_cnt_q + HCW'(1) : '0;
    timeout_d  = rel_forced;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign rel_forced = 1'b0;
`endif

  // First set request at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign owner_rel = done[gnt_id_q] | ~req[gnt_id_q];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    bus_valid_d = bus_valid_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE, TURN: begin
        gnt_d       = '0;
        bus_valid_d = 1'b0;
        state_d     = IDLE;
        if (win_found) begin
          state_d        = OWN;
          gnt_d[win_id]  = 1'b1;
          gnt_id_d       = win_id;
          bus_valid_d    = 1'b1;
        end
      end
      OWN: begin
        if (owner_rel || rel_forced) begin
          state_d     = TURN;
          gnt_d       = '0;
          bus_valid_d = 1'b0;
          rr_ptr_d    = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      bus_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      bus_valid_q <= bus_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    bus_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus_valid_q && gnt_id_q == IDW'(i)) begin
        bus_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign bus_valid = bus_valid_q;

endmodule
